// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants and the coordinate type shared with the colour generator.
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_FP = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP = 33;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  typedef logic [9:0] coord_t;
endpackage

// File: rtl/vga_timing_gen_pix_clk_en.sv
// pix_clk_en: divides clk into a one-clock pixel strobe and a registered DAC pixel clock.
module pix_clk_en #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic pix_en,
  output logic vga_clk
);
  localparam int W = $clog2(CLK_DIV);
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);
  localparam logic [W-1:0] HALF = W'(CLK_DIV / 2);
  logic [W-1:0] div_cnt, div_nxt;
  assign pix_en = div_cnt == LAST;
  assign div_nxt = pix_en ? '0 : div_cnt + 1'b1;
  // vga_clk is registered from the next count so it tracks div_cnt and rises mid-pixel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      vga_clk <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      vga_clk <= div_nxt >= HALF;
    end
  end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel strobe, h/v counters and sync/blank generation for the VGA DAC.
module vga_timing_gen
  import vga_pkg::coord_t;
#(
  parameter int CLK_DIV = 2,
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP = vga_pkg::H_FP,
  parameter int H_SYNC = vga_pkg::H_SYNC,
  parameter int H_BP = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP = vga_pkg::V_FP,
  parameter int V_SYNC = vga_pkg::V_SYNC,
  parameter int V_BP = vga_pkg::V_BP,
  parameter int SYNC_DELAY = 1
) (
  input  logic   clk,
  input  logic   rst,
  output logic   pix_en,
  output coord_t x,
  output coord_t y,
  output logic   active,
  output logic   frame_start,
  output logic   line_start,
  output logic   hsync,
  output logic   vsync,
  output logic   blank_n,
  output logic   sync_n,
  output logic   vga_clk
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);
  localparam coord_t H_ACT = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT = coord_t'(V_ACTIVE);
  localparam coord_t HS_BEG = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_END = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VS_BEG = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_END = coord_t'(V_ACTIVE + V_FP + V_SYNC);
  logic hs_raw, vs_raw;
  logic [2:0] stage [SYNC_DELAY+1];
  pix_clk_en #(.CLK_DIV(CLK_DIV)) u_pix (
    .clk(clk),
    .rst(rst),
    .pix_en(pix_en),
    .vga_clk(vga_clk)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (pix_en) begin
      x <= x == H_LAST ? '0 : x + 1'b1;
      if (x == H_LAST) y <= y == V_LAST ? '0 : y + 1'b1;
    end
  end
  assign active = x < H_ACT && y < V_ACT;
  assign frame_start = pix_en && x == '0 && y == '0;
  assign line_start = pix_en && x == '0;
  assign hs_raw = !(x >= HS_BEG && x < HS_END);
  assign vs_raw = !(y >= VS_BEG && y < VS_END);
  assign sync_n = 1'b0;
  // stage[k] holds {hsync, vsync, blank_n} as they were k pixels ago
  assign stage[0] = {hs_raw, vs_raw, active};
  for (genvar g = 0; g < SYNC_DELAY; g++) begin : g_dly
    always_ff @(posedge clk or posedge rst) begin
      if (rst) stage[g+1] <= 3'b110;
      else if (pix_en) stage[g+1] <= stage[g];
    end
  end
  assign {hsync, vsync, blank_n} = stage[SYNC_DELAY];
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of a default instance and a shrunken-timing CLK_DIV=4/SYNC_DELAY=2 instance.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic a_pix_en, a_active, a_fs, a_ls, a_hs, a_vs, a_bn, a_sn, a_vc;
  logic b_pix_en, b_active, b_fs, b_ls, b_hs, b_vs, b_bn, b_sn, b_vc;
  logic [9:0] a_x, a_y, b_x, b_y;
  int vectors = 0;
  int miscompares = 0;
  vga_timing_gen dut_a (
    .clk(clk), .rst(rst), .pix_en(a_pix_en), .x(a_x), .y(a_y), .active(a_active),
    .frame_start(a_fs), .line_start(a_ls), .hsync(a_hs), .vsync(a_vs),
    .blank_n(a_bn), .sync_n(a_sn), .vga_clk(a_vc)
  );
  // 16 pixels x 10 lines so whole frames fit in a short run
  vga_timing_gen #(
    .CLK_DIV(4), .SYNC_DELAY(2),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_b (
    .clk(clk), .rst(rst), .pix_en(b_pix_en), .x(b_x), .y(b_y), .active(b_active),
    .frame_start(b_fs), .line_start(b_ls), .hsync(b_hs), .vsync(b_vs),
    .blank_n(b_bn), .sync_n(b_sn), .vga_clk(b_vc)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic chk_idle(input string t);
    chk({t, "_a"}, {a_x, a_y, a_pix_en, a_fs, a_ls, a_hs, a_vs, a_bn, a_vc, a_sn}, {20'd0, 8'b00011000});
    chk({t, "_b"}, {b_x, b_y, b_pix_en, b_fs, b_ls, b_hs, b_vs, b_bn, b_vc, b_sn}, {20'd0, 8'b00011000});
  endtask
  task automatic post_release(input string t);
    tick();
    chk({t, "_c1a"}, {a_pix_en, a_fs, a_ls, a_vc, a_x, a_y}, {4'b1111, 20'd0});
    chk({t, "_c1b"}, {b_pix_en, b_fs, b_vc}, 3'b000);
    tick();
    chk({t, "_c2a"}, {a_pix_en, a_fs, a_vc, a_bn, a_x}, {4'b0001, 10'd1});
    chk({t, "_c2b"}, {b_pix_en, b_vc}, 2'b01);
    tick();
    chk({t, "_c3b"}, {b_pix_en, b_fs, b_ls, b_vc, b_x, b_y}, {4'b1111, 20'd0});
  endtask
  initial begin
    int ls_t[$];
    int fs_t[$];
    int pe, hs_lo, bn_hi, vs_lo, vc_hi, hs_x, hs_fx, vs_f, xmax, viol, found;
    logic prev_hs, prev_vs;
    repeat (10) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    post_release("rel1");
    pe = 0; hs_lo = 0; bn_hi = 0; hs_x = -1; xmax = 0; viol = 0;
    for (int i = 0; i < 3200; i++) begin
      tick();
      if (a_ls) ls_t.push_back(i);
      if (i < 1600) begin
        if (a_pix_en) begin
          pe++;
          if (!a_hs) hs_lo++;
          if (a_bn) bn_hi++;
        end
        if (!a_hs && hs_x < 0) hs_x = int'(a_x);
        if (int'(a_x) > xmax) xmax = int'(a_x);
      end
      if (a_active && (a_x >= 10'd640 || a_y >= 10'd480)) viol++;
    end
    chk("a_pix_per_line", pe, 800);
    chk("a_hsync_width", hs_lo, 96);
    chk("a_hsync_start_x", hs_x, 657);
    chk("a_blank_n_line", bn_hi, 640);
    chk("a_x_max", xmax, 799);
    chk("a_line_start_gap", ls_t.size() >= 2 ? ls_t[1] - ls_t[0] : -1, 1600);
    chk("a_xy_after_lines", {a_y, a_x}, {10'd2, 10'd1});
    chk("a_active_bound", viol, 0);
    pe = 0; hs_lo = 0; bn_hi = 0; vs_lo = 0; vc_hi = 0; hs_fx = -1; vs_f = -1; viol = 0;
    prev_hs = b_hs; prev_vs = b_vs;
    for (int i = 0; i < 1280; i++) begin
      tick();
      if (b_fs) fs_t.push_back(i);
      if (b_vc) vc_hi++;
      if (b_pix_en) begin
        pe++;
        if (!b_hs) hs_lo++;
        if (!b_vs) vs_lo++;
        if (b_bn) bn_hi++;
      end
      if (prev_hs && !b_hs && hs_fx < 0) hs_fx = int'(b_x);
      if (prev_vs && !b_vs && vs_f < 0) vs_f = int'({b_y, b_x});
      if (b_active && (b_x >= 10'd8 || b_y >= 10'd6)) viol++;
      prev_hs = b_hs;
      prev_vs = b_vs;
    end
    chk("b_pix_en_rate", pe, 320);
    chk("b_vga_clk_duty", vc_hi, 640);
    chk("b_hsync_low", hs_lo, 60);
    chk("b_vsync_low", vs_lo, 64);
    chk("b_blank_n_high", bn_hi, 96);
    chk("b_hsync_fall_x", hs_fx, 12);
    chk("b_vsync_fall_yx", vs_f, int'({10'd7, 10'd2}));
    chk("b_frame_gap", fs_t.size() >= 2 ? fs_t[1] - fs_t[0] : -1, 640);
    chk("b_active_bound", viol, 0);
    found = 0;
    for (int i = 0; i < 2000 && found == 0; i++) begin
      tick();
      if (b_x == 10'd5 && b_y == 10'd3) found = 1;
    end
    chk("b_reach_5_3", found, 1);
    tick();
    rst = 1'b1;
    #1;
    chk_idle("midrst");
    repeat (3) @(negedge clk);
    chk_idle("rsthold");
    rst = 1'b0;
    post_release("rel2");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
